// File: rtl/demux_s.sv
// Serial-to-parallel demultiplexer: routes one input bit per write either to an
// indexed bit of out (direct mode) or into a 16-bit sequential frame.
module demux_s #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    input  logic [3:0]  sel,
    input  logic        wr,
    input  logic        mode,
    input  logic        start,
    input  logic        frame_ready,
    output logic [15:0] out,
    output logic [3:0]  cnt,
    output logic        frame_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t      state, state_nx;
    logic [15:0] out_nx;
    logic [3:0]  cnt_nx;
    logic        ovf_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out      <= RESET_VAL;
            cnt      <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            out      <= out_nx;
            cnt      <= cnt_nx;
            overflow <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        out_nx   = out;
        cnt_nx   = cnt;
        ovf_nx   = overflow;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (wr) out_nx[sel] = in;
                end else if (start) begin
                    state_nx = FILL;
                    ovf_nx   = 1'b0;
                    cnt_nx   = {3'b000, wr};
                    if (wr) out_nx[0] = in;
                end
            end
            FILL: begin
                // A restart keeps the partially written bits; only the index rewinds.
                if (start) begin
                    ovf_nx = 1'b0;
                    cnt_nx = {3'b000, wr};
                    if (wr) out_nx[0] = in;
                end else if (wr) begin
                    out_nx[cnt] = in;
                    cnt_nx      = cnt + 4'd1;
                    if (cnt == 4'd15) state_nx = HOLD;
                end
            end
            HOLD: begin
                if (frame_ready && start) begin
                    state_nx = FILL;
                    cnt_nx   = {3'b000, wr};
                    if (wr) out_nx[0] = in;
                end else begin
                    if (frame_ready) state_nx = IDLE;
                    if (wr) ovf_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Derived purely from the state register, so still free of input paths.
    assign frame_valid = (state == HOLD);

endmodule

// File: tb/tb_demux_s.sv
// Bench for demux_s: directed scenarios plus randomized traffic, checked each
// cycle against a frame-level reference model.
module tb_demux_s;

    localparam logic [15:0] RV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_in;
    logic [3:0]  sel;
    logic        wr;
    logic        mode;
    logic        start;
    logic        frame_ready;
    logic [15:0] out;
    logic [3:0]  cnt;
    logic        frame_valid;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bit array, write index, phase 0=idle 1=filling 2=holding.
    bit m_bits[16];
    int m_idx;
    int m_phase;
    bit m_ovf;

    demux_s #(.RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .in(d_in), .sel(sel), .wr(wr), .mode(mode),
        .start(start), .frame_ready(frame_ready), .out(out), .cnt(cnt),
        .frame_valid(frame_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m_bits[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bits[i] = RV[i];
        m_idx = 0; m_phase = 0; m_ovf = 0;
    endtask

    task automatic begin_frame(input bit clear_ovf);
        m_phase = 1;
        if (clear_ovf) m_ovf = 0;
        if (wr) begin m_bits[0] = d_in; m_idx = 1; end
        else m_idx = 0;
    endtask

    task automatic model_step();
        if (rst) begin model_reset(); return; end
        case (m_phase)
            0: if (!mode) begin
                   if (wr) m_bits[int'(sel)] = d_in;
               end else if (start) begin_frame(1);
            1: if (start) begin_frame(1);
               else if (wr) begin
                   m_bits[m_idx] = d_in;
                   m_idx++;
                   if (m_idx == 16) begin m_idx = 0; m_phase = 2; end
               end
            default: if (frame_ready && start) begin_frame(0);
                     else begin
                         if (wr) m_ovf = 1;
                         if (frame_ready) m_phase = 0;
                     end
        endcase
    endtask

    // Drive inputs after a falling edge, clock them in, compare at the next falling edge.
    task automatic cycle(input logic i_rst, input logic i_in, input logic [3:0] i_sel,
                         input logic i_wr, input logic i_mode, input logic i_start,
                         input logic i_fr);
        rst = i_rst; d_in = i_in; sel = i_sel; wr = i_wr;
        mode = i_mode; start = i_start; frame_ready = i_fr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out", 32'(out), 32'(m_word()));
        check("cnt", 32'(cnt), 32'(m_idx));
        check("frame_valid", 32'(frame_valid), 32'(m_phase == 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic fill_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) cycle(0, w[i], 4'd0, 1, 1, 0, 0);
    endtask

    initial begin
        logic [15:0] w;
        rst = 1; d_in = 0; sel = 0; wr = 0; mode = 0; start = 0; frame_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'(RV));
        check("rst_cnt", 32'(cnt), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 0;

        // Direct mode
        cycle(0, 1, 4'd5, 1, 0, 0, 0);  check("dir1", 32'(out), 32'h0020);
        cycle(0, 1, 4'd15, 1, 0, 0, 0); check("dir2", 32'(out), 32'h8020);
        cycle(0, 0, 4'd5, 1, 0, 0, 0);  check("dir3", 32'(out), 32'h8000);
        check("dir_fv", 32'(frame_valid), 0);
        cycle(0, 1, 4'd3, 0, 0, 1, 0);  check("start_ign_m0", 32'(cnt), 0);

        // Sequential frame
        cycle(0, 0, 4'd0, 0, 1, 1, 0);
        fill_word(16'hA5C3);
        check("seq_fv", 32'(frame_valid), 1);
        check("seq_out", 32'(out), 32'hA5C3);
        check("seq_cnt", 32'(cnt), 0);
        cycle(0, 0, 4'd0, 0, 1, 0, 1);  check("seq_acc_fv", 32'(frame_valid), 0);
        cycle(0, 0, 4'd0, 1, 0, 0, 0);  check("seq_idle", 32'(out), 32'hA5C2);

        // Backpressure and overflow
        cycle(0, 0, 4'd0, 0, 1, 1, 0);
        fill_word(16'h3C5A);
        for (int i = 0; i < 5; i++) begin
            cycle(0, ~d_in, 4'd0, (i == 1 || i == 3), 1, 0, 0);
            check("bp_out", 32'(out), 32'h3C5A);
            check("bp_fv", 32'(frame_valid), 1);
            if (i >= 1) check("bp_ovf", 32'(overflow), 1);
        end
        cycle(0, 0, 4'd0, 0, 1, 0, 1);  check("acc_ovf_held", 32'(overflow), 1);
        cycle(0, 0, 4'd0, 0, 1, 1, 0);  check("start_clr_ovf", 32'(overflow), 0);

        // Restart mid-frame
        for (int i = 0; i < 7; i++) cycle(0, 0, 4'd0, 1, 1, 0, 0);
        check("rs_cnt7", 32'(cnt), 7);
        cycle(0, 1, 4'd0, 1, 1, 1, 0);
        check("rs_cnt", 32'(cnt), 1);
        check("rs_bit0", 32'(out[0]), 1);
        w = 16'h6B2D;
        for (int i = 1; i < 16; i++) begin
            if (i == 15) check("rs_fv_early", 32'(frame_valid), 0);
            cycle(0, w[i], 4'd7, 1, 1, 0, 0);
        end
        check("rs_fv", 32'(frame_valid), 1);
        check("rs_out", 32'(out), 32'(w));

        // Back-to-back frames: mode=0 and sel=9 must be ignored in FILL
        cycle(0, 0, 4'd0, 0, 0, 1, 1);
        check("b2b_fv", 32'(frame_valid), 0);
        check("b2b_cnt", 32'(cnt), 0);
        cycle(0, 1, 4'd9, 1, 0, 0, 0);
        check("b2b_cnt1", 32'(cnt), 1);
        check("b2b_bit0", 32'(out[0]), 1);

        // Asynchronous reset at cnt=9
        for (int i = 0; i < 8; i++) cycle(0, 1, 4'd0, 1, 1, 0, 0);
        check("ar_cnt9", 32'(cnt), 9);
        #2 rst = 1;
        #1;
        check("ar_out", 32'(out), 32'(RV));
        check("ar_cnt", 32'(cnt), 0);
        check("ar_fv", 32'(frame_valid), 0);
        #1 rst = 0;
        model_reset();
        cycle(0, 1, 4'd0, 1, 1, 0, 0);
        check("ar_no_resume", 32'(cnt), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_wr, r_st;
            r_rst = ($urandom_range(0, 299) == 0);
            r_wr  = $urandom_range(0, 1);
            r_st  = ($urandom_range(0, 15) == 0);
            if (m_phase == 2 && r_st) r_wr = 0;
            cycle(r_rst, 1'($urandom), 4'($urandom), r_wr,
                  ($urandom_range(0, 3) != 0), r_st, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_s.md
DEMUX_S -- requirements
Module: demux_s

Interface
REQ-001 Parameter RESET_VAL, default 16'h0000: the value loaded into out on reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port in, input, 1 bit: the serial data bit to be routed.
REQ-005 Port sel, input, 4 bits: destination bit index, used in direct mode.
REQ-006 Port wr, input, 1 bit: write strobe; one bit is written per cycle while high.
REQ-007 Port mode, input, 1 bit: 0 = direct (indexed by sel), 1 = sequential (auto-index).
REQ-008 Port start, input, 1 bit: begins or restarts a sequential frame.
REQ-009 Port frame_ready, input, 1 bit: the consumer accepts the completed frame.
REQ-010 Port out, output, 16 bits: the registered demultiplexed word.
REQ-011 Port cnt, output, 4 bits: the current sequential write index.
REQ-012 Port frame_valid, output, 1 bit: a complete 16-bit frame is held on out.
REQ-013 Port overflow, output, 1 bit: sticky flag; a write was attempted while a frame was held.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FILL and HOLD.
REQ-015 Direct mode (IDLE, mode=0, wr=1, start=0):
- out[sel] <= in on the next edge.
- All other bits of out hold their value.
- Latency is 1 cycle.
- State stays IDLE.
REQ-016 Start from IDLE (mode=1, start=1):
- Transition to FILL.
- cnt <= 0, or cnt <= 1 with out[0] <= in if wr=1 in the same cycle.
REQ-017 In IDLE, start SHALL be ignored when mode=0.
REQ-018 FILL write (wr=1, start=0):
- out[cnt] <= in.
- cnt <= cnt+1.
- sel is ignored.
REQ-019 FILL, end of frame: a write at cnt=15 SHALL move the FSM to HOLD, wrap cnt to 0, and set frame_valid=1 on the next cycle.
REQ-020 FILL with start=1 (restart):
- cnt <= 0, or cnt <= 1 with out[0] <= in if wr=1.
- Already-written bits of out are not cleared.
REQ-021 In FILL and HOLD, mode SHALL be ignored; mode is sampled only in IDLE.
REQ-022 In FILL with wr=0 and start=0, all state SHALL hold; gaps between writes are unbounded.
REQ-023 HOLD, write attempt: wr=1 SHALL NOT modify out or cnt, and SHALL set overflow=1.
REQ-024 HOLD, frame accepted (frame_ready=1):
- frame_valid <= 0.
- Next state is FILL if start=1 that cycle (start handling per REQ-020), otherwise IDLE.
REQ-025 HOLD, frame not accepted (frame_ready=0): frame_valid and out SHALL remain stable until acceptance.
REQ-026 frame_ready SHALL be ignored outside HOLD.
REQ-027 overflow SHALL be cleared only by reset or by start=1 accepted in IDLE/FILL.
REQ-028 frame_valid SHALL be 1 exactly when the state is HOLD.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 On rst=1, asynchronously and regardless of clk:
- out = RESET_VAL.
- cnt = 0.
- frame_valid = 0.
- overflow = 0.
- State = IDLE.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, only direct mode or a new start resumes operation.
REQ-032 On the first clk edge after rst deasserts, operation SHALL proceed normally with no extra latency.

Verification
REQ-033 Direct mode, with RESET_VAL=0:
- Stimulus: mode=0; write in=1 at sel=5, then in=1 at sel=15, then in=0 at sel=5.
- Required: out=16'h0020, then 16'h8020, then 16'h8000.
- Required: frame_valid=0 throughout.
REQ-034 Sequential frame:
- Stimulus: mode=1, start pulse, then 16 consecutive wr cycles with in = bits of 16'hA5C3, LSB first.
- Required: frame_valid=1 on the cycle after the 16th write, with out=16'hA5C3 and cnt=0.
- Required: after a frame_ready pulse, frame_valid=0 and the state is IDLE.
REQ-035 Backpressure and overflow:
- Stimulus: frame held with frame_ready=0 for 5 cycles while wr=1 on 2 of them.
- Required: out unchanged, overflow=1, frame_valid=1 throughout.
- Required: start in IDLE after acceptance clears overflow.
REQ-036 Restart mid-frame:
- Stimulus: after 7 writes, start=1 together with wr=1 and in=1.
- Required: cnt=1, out[0]=1; frame completes after 15 further writes.
REQ-037 Back-to-back frames: frame_ready=1 together with start=1 in HOLD SHALL enter FILL with cnt=0 and no idle cycle.
REQ-038 Asynchronous reset mid-frame:
- Stimulus: rst pulse between clk edges at cnt=9.
- Required: out=RESET_VAL, cnt=0, frame_valid=0 immediately, before the next edge.
